// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential signed restoring divider, one quotient bit per clock
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         division request, sampled only while busy=0
//   dvd, dvs      signed dividend / divisor, captured with start
//   quot, rem     signed quotient / remainder (truncating), held until next result
//   busy          high while a division is in progress (RUN, FIX)
//   done          one-cycle pulse, results valid in that cycle
//   dz, ovf       divide-by-zero and signed-overflow flags for the last result
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dq;        // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH:0]   prem;      // partial remainder, one guard bit for the trial subtract
    logic             q_neg;
    logic             r_neg;
    logic             dz_r;
    logic             ovf_r;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (cnt == CW'(WIDTH));

    // Unsigned magnitudes: negating the most-negative value yields 2^(WIDTH-1),
    // which is exact when the result is read as unsigned.
    assign dvd_mag_in = dvd[WIDTH-1] ? -dvd : dvd;
    assign dvs_mag_in = dvs[WIDTH-1] ? -dvs : dvs;

    assign shifted = {prem[WIDTH-1:0], dq[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag};

    // Special cases override the restoring result but the FSM path (and so the
    // latency) is identical for every operand pair.
    always_comb begin
        quot_fix = q_neg ? -dq : dq;
        rem_fix  = r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
        if (dz_r) begin
            quot_fix = '1;
            rem_fix  = dvd_r;
        end else if (ovf_r) begin
            quot_fix = dvd_r;
            rem_fix  = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_step ? FIX : RUN;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN) || (state == FIX);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dvd_r   <= '0;
            dvs_mag <= '0;
            dq      <= '0;
            prem    <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz_r    <= 1'b0;
            ovf_r   <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                dvd_r   <= dvd;
                dvs_mag <= dvs_mag_in;
                dq      <= dvd_mag_in;
                prem    <= '0;
                q_neg   <= dvd[WIDTH-1] ^ dvs[WIDTH-1];
                r_neg   <= dvd[WIDTH-1];
                dz_r    <= (dvs == '0);
                ovf_r   <= (dvd == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs == '1);
            end else if (state == RUN && !last_step) begin
                // Restoring step: keep the trial difference only if non-negative.
                prem <= trial[WIDTH] ? shifted : trial;
                dq   <= {dq[WIDTH-2:0], ~trial[WIDTH]};
                cnt  <= cnt + 1'b1;
            end else if (state == FIX) begin
                quot <= quot_fix;
                rem  <= rem_fix;
                dz   <= dz_r;
                ovf  <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (WIDTH=8)
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         busy;
    logic         done;
    logic         dz;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .dvd   (dvd),
        .dvs   (dvs),
        .quot  (quot),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed truncating division from plain integer arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output logic o);
        int sa;
        int sb;
        int iq;
        int ir;
        sa = $signed(a);
        sb = $signed(b);
        z  = 1'b0;
        o  = 1'b0;
        if (sb == 0) begin
            z = 1'b1;
            q = '1;
            r = a;
        end else if (sa == -(2 ** (W - 1)) && sb == -1) begin
            o = 1'b1;
            q = a;
            r = '0;
        end else begin
            iq = sa / sb;
            ir = sa % sb;
            q  = iq[W-1:0];
            r  = ir[W-1:0];
        end
    endfunction

    // Issues a division at the next edge (edge N), checks busy over the run,
    // done after edge N+W+2 and the results. ign>0 re-asserts start with other
    // operands at edge N+ign; otherwise operand inputs are scrambled during RUN.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int ign,
                          input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        logic         eo;
        logic         busy_ok;
        model(a, b, eq, er, ez, eo);
        dvd   = a;
        dvs   = b;
        start = 1'b1;
        tick();
        start   = 1'b0;
        busy_ok = busy && !done;
        for (int k = 1; k <= W + 1; k++) begin
            if (k == ign) begin
                start = 1'b1;
                dvd   = 8'd50;
                dvs   = 8'd5;
            end else begin
                dvd = W'($urandom);
                dvs = W'($urandom);
            end
            tick();
            start = 1'b0;
            busy_ok = busy_ok && busy && !done;
        end
        chk({tag, " busy window"}, {31'd0, busy_ok}, 32'd1);
        tick();
        chk({tag, " done"}, {30'd0, done, busy}, 32'd2);
        chk({tag, " quot"}, {24'd0, quot}, {24'd0, eq});
        chk({tag, " rem"}, {24'd0, rem}, {24'd0, er});
        chk({tag, " flags"}, {30'd0, dz, ovf}, {30'd0, ez, eo});
    endtask

    initial begin
        logic         saw_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset outputs", {busy, done, dz, ovf, quot, rem}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        do_div(8'd17, 8'd3, 0, "17/3");
        do_div(8'hF9, 8'd2, 0, "-7/2");
        do_div(8'd7, 8'hFE, 0, "7/-2");
        do_div(8'd7, 8'd0, 0, "7/0");
        do_div(8'h80, 8'hFF, 0, "min/-1");
        do_div(8'h80, 8'd1, 0, "min/1");
        do_div(8'd100, 8'd7, 4, "100/7 ignore");
        do_div(8'd50, 8'd5, 0, "50/5 from done");

        // Reset mid-operation: outputs clear without a clock, no done follows.
        dvd   = 8'd17;
        dvs   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("abort outputs", {busy, done, dz, ovf, quot, rem}, 32'd0);
        tick();
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < W + 6; k++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        chk("abort no done", {31'd0, saw_done}, 32'd0);
        do_div(8'd3, 8'd17, 0, "3/17 after reset");

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: ra = 8'h80;
                2: rb = 8'hFF;
                3: begin ra = 8'h80; rb = 8'h80; end
                default: ;
            endcase
            do_div(ra, rb, 0, $sformatf("rand%0d %0h/%0h", i, ra, rb));
        end

        tick();
        chk("idle after done", {30'd0, busy, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
